// File: rtl/nibble_serial_adder.sv
// Multi-word adder controller around an external combinational 4-bit adder slice.
// Operands are fed LSB nibble first; the carry is chained through a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 c_in,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry_out,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | waiting for operands, in_ready high
  // RUN    | one nibble per cycle through the slice
  // DONE   | result held, out_valid high until out_ready

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;

  logic [3:0]    a_nib, b_nib;

  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == i[IW-1:0]) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == i[IW-1:0]) sum_d[4*i +: 4] = add_sum;
        end
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // index wraps to 0 so it never exceeds the last nibble
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    add_a     = (state_q == S_RUN) ? a_nib : 4'd0;
    add_b     = (state_q == S_RUN) ? b_nib : 4'd0;
    add_cin   = (state_q == S_RUN) ? carry_q : 1'b0;
    sum       = sum_q;
    carry_out = cout_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a behavioural adder slice
// and a result scoreboard.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic        c_in;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  // external combinational slice
  logic [4:0] slice_res;
  assign slice_res = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum   = slice_res[3:0];
  assign add_cout  = slice_res[4];

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .c_in(c_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; the accept happens on the next posedge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
    check("accept_in_ready", 32'(in_ready), 32'd1);
    op_a = a; op_b = b; c_in = cin; in_valid = 1'b1;
    sb_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the accept edge; returns at the first DONE negedge.
  task automatic run_phase(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           output logic [16:0] res);
    logic [3:0] na, nb;
    logic [4:0] s5;
    logic       cr;
    cr = cin;
    for (int k = 0; k < 4; k++) begin
      na = a[4*k +: 4];
      nb = b[4*k +: 4];
      check($sformatf("run%0d_add_a", k), 32'(add_a), 32'(na));
      check($sformatf("run%0d_add_b", k), 32'(add_b), 32'(nb));
      check($sformatf("run%0d_add_cin", k), 32'(add_cin), 32'(cr));
      check($sformatf("run%0d_out_valid", k), 32'(out_valid), 32'd0);
      check($sformatf("run%0d_busy", k), 32'(busy), 32'd1);
      check($sformatf("run%0d_in_ready", k), 32'(in_ready), 32'd0);
      s5 = {1'b0, na} + {1'b0, nb} + {4'd0, cr};
      cr = s5[4];
      @(negedge clk);
    end
    check("done_out_valid_latency", 32'(out_valid), 32'd1);
    check("done_add_a_zero", 32'(add_a), 32'd0);
    check("done_add_cin_zero", 32'(add_cin), 32'd0);
    if (sb_q.size() == 0) begin
      res = '0;
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      res = sb_q.pop_front();
      check("result_sum", 32'(sum), 32'(res[15:0]));
      check("result_carry_out", 32'(carry_out), 32'(res[16]));
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] res;
    accept(a, b, cin);
    run_phase(a, b, cin, res);
    handoff();
  endtask

  initial begin
    logic [16:0] held;
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_carry_out", 32'(carry_out), 32'd0);
    check("reset_add_a", 32'(add_a), 32'd0);
    check("reset_add_b", 32'(add_b), 32'd0);
    check("reset_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);
    run_op(16'h00A7, 16'h0069, 1'b0);

    // backpressure: result held, new operands ignored in DONE
    accept(16'h8421, 16'h9876, 1'b1);
    run_phase(16'h8421, 16'h9876, 1'b1, held);
    op_a = 16'h1111; op_b = 16'h2222; c_in = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_sum_stable", 32'(sum), 32'(held[15:0]));
      check("bp_carry_stable", 32'(carry_out), 32'(held[16]));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    sb_q.push_back({1'b0, op_a} + {1'b0, op_b} + {16'd0, c_in});
    @(negedge clk);
    in_valid = 1'b0;
    run_phase(16'h1111, 16'h2222, 1'b1, held);
    handoff();

    // reset during the second RUN cycle
    accept(16'h5A5A, 16'hA5A5, 1'b1);
    @(negedge clk);
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb_q.pop_back());
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry_out", 32'(carry_out), 32'd0);
    check("midrst_add_a", 32'(add_a), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_out_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0003, 16'h0004, 1'b0);

    for (int n = 0; n < 6; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
